// File: rtl/fnn_pkg.sv
// Shared types for the feed-forward neural network datapath.
//   DATA_WIDTH  : default activation width
//   ser_state_t : layer-output serializer FSM states
//   act_t       : one activation value
package fnn_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  typedef logic [DATA_WIDTH-1:0] act_t;

endpackage

// File: rtl/layer_out_serializer.sv
// layer_out_serializer
//   Captures all numNeurons activations of one layer in parallel once every
//   neuron reports outvalid. It then replays them one per cycle as the next
//   layer's myinput/myinputValid stream. Two protocol faults raise sticky
//   flags: neurons that do not finish together, and a new layer result that
//   arrives while the previous one is still streaming.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_data       numNeurons*dataWidth packed activations, neuron i at [i*dataWidth +: dataWidth]
//   in_valid      per-neuron outvalid
//   err_clr       synchronous clear of both sticky error flags
//   out_data      serial activation (0 whenever out_valid is low)
//   out_valid     serial valid
//   out_last      marks element numNeurons-1
//   busy          high for the numNeurons cycles of the stream
//   err_overrun   sticky: capture condition seen while streaming
//   err_mismatch  sticky: in_valid partially set
module layer_out_serializer
  import fnn_pkg::*;
#(
  parameter int numNeurons = 30,
  parameter int dataWidth  = DATA_WIDTH,
  parameter int cntWidth   = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic [numNeurons-1:0]           in_valid,
  input  logic                            err_clr,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic                            out_last,
  output logic                            busy,
  output logic                            err_overrun,
  output logic                            err_mismatch
);

  ser_state_t           state_q;
  logic [cntWidth-1:0]  index_q;
  logic [dataWidth-1:0] buf_q [numNeurons];
  logic [dataWidth-1:0] out_data_q;
  logic                 out_valid_q, out_last_q, busy_q;
  logic                 err_overrun_q, err_mismatch_q;

  logic capture, mismatch, at_last;
  logic err_overrun_d, err_mismatch_d;

  assign capture  = &in_valid;
  assign mismatch = (|in_valid) && !capture;
  assign at_last  = (index_q == cntWidth'(numNeurons - 1));

  // Sticky flags: a new event in the same cycle as err_clr keeps the flag set.
  assign err_overrun_d  = (err_overrun_q & ~err_clr) | (capture && (state_q == SHIFT));
  assign err_mismatch_d = (err_mismatch_q & ~err_clr) | mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      index_q        <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_mismatch_q <= 1'b0;
      for (int i = 0; i < numNeurons; i++) buf_q[i] <= '0;
    end else begin
      err_overrun_q  <= err_overrun_d;
      err_mismatch_q <= err_mismatch_d;
      case (state_q)
        IDLE: begin
          // Outputs drop in the cycle after the last element.
          out_data_q  <= '0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
          if (capture) begin
            for (int i = 0; i < numNeurons; i++)
              buf_q[i] <= in_data[i*dataWidth +: dataWidth];
            index_q <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // busy is registered alongside out_valid so both cover the same cycles.
          out_data_q  <= buf_q[index_q];
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
          out_last_q  <= at_last;
          if (at_last) begin
            index_q <= '0;
            state_q <= IDLE;
          end else begin
            index_q <= index_q + cntWidth'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign err_overrun  = err_overrun_q;
  assign err_mismatch = err_mismatch_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
module tb_layer_out_serializer;

  logic clk, rst;

  // Small instance (4 neurons)
  logic [63:0] a_data;
  logic [3:0]  a_valid;
  logic        a_clr;
  logic [15:0] a_odata;
  logic        a_ovalid, a_olast, a_busy, a_eov, a_emm;

  // Default-size instance (30 neurons)
  logic [479:0] b_data;
  logic [29:0]  b_valid;
  logic         b_clr;
  logic [15:0]  b_odata;
  logic         b_ovalid, b_olast, b_busy, b_eov, b_emm;

  int n_chk = 0;
  int n_fail = 0;

  layer_out_serializer #(.numNeurons(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .err_clr(a_clr),
    .out_data(a_odata), .out_valid(a_ovalid), .out_last(a_olast), .busy(a_busy),
    .err_overrun(a_eov), .err_mismatch(a_emm));

  layer_out_serializer dut30 (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .err_clr(b_clr),
    .out_data(b_odata), .out_valid(b_ovalid), .out_last(b_olast), .busy(b_busy),
    .err_overrun(b_eov), .err_mismatch(b_emm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial word {valid,last,busy,data} for stream position k of an n-element layer.
  function automatic logic [18:0] exp_word(input int k, input int n, input logic [15:0] w);
    if (k >= 0 && k < n) return {1'b1, (k == n - 1), 1'b1, w};
    return '0;
  endfunction

  task automatic test_reset();
    logic [20:0] got;
    rst = 1'b1; a_valid = '0; a_data = '0; a_clr = 1'b0;
    b_valid = '0; b_data = '0; b_clr = 1'b0;
    #13;
    got = {a_ovalid, a_olast, a_busy, a_odata, a_eov, a_emm};
    n_chk++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_small got=%h exp=0", got); end
    got = {b_ovalid, b_olast, b_busy, b_odata, b_eov, b_emm};
    n_chk++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_wide got=%h exp=0", got); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [15:0] w [4];
    logic [18:0] got, exp;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) w[i] = (p == 0) ? 16'(i + 1) : 16'($urandom);
      for (int i = 0; i < 4; i++) a_data[i*16 +: 16] = w[i];
      a_valid = 4'hF;
      @(negedge clk);
      a_valid = '0; a_data = {$urandom, $urandom};
      n_chk++;
      if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL stream_capture_cycle valid=%b exp=0", a_ovalid); end
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        got = {a_ovalid, a_olast, a_busy, a_odata};
        exp = exp_word(k, 4, (k < 4) ? w[k] : 16'h0);
        n_chk++;
        if (got !== exp) begin n_fail++; $display("FAIL stream p=%0d k=%0d got=%h exp=%h", p, k, got, exp); end
      end
    end
    n_chk++;
    if ({a_eov, a_emm} !== 2'b00) begin n_fail++; $display("FAIL stream_no_err got=%b exp=00", {a_eov, a_emm}); end
  endtask

  task automatic test_mismatch();
    a_valid = 4'b0111; a_data = {$urandom, $urandom};
    @(negedge clk);
    a_valid = '0;
    n_chk++;
    if (a_emm !== 1'b1) begin n_fail++; $display("FAIL mismatch_set got=%b exp=1", a_emm); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (a_ovalid !== 1'b0 || a_emm !== 1'b1) begin
        n_fail++; $display("FAIL mismatch_nocap k=%0d valid=%b emm=%b exp=0/1", k, a_ovalid, a_emm);
      end
    end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    n_chk++;
    if (a_emm !== 1'b0) begin n_fail++; $display("FAIL mismatch_clr got=%b exp=0", a_emm); end
    // Clear and a new partial pattern together: the flag stays set.
    a_clr = 1'b1; a_valid = 4'($urandom_range(1, 14));
    @(negedge clk);
    a_clr = 1'b0; a_valid = '0;
    n_chk++;
    if (a_emm !== 1'b1) begin n_fail++; $display("FAIL mismatch_set_wins got=%b exp=1", a_emm); end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    n_chk++;
    if (a_emm !== 1'b0) begin n_fail++; $display("FAIL mismatch_clr2 got=%b exp=0", a_emm); end
  endtask

  task automatic test_overrun();
    logic [15:0] w [4];
    logic [18:0] got, exp;
    // Second result arrives two cycles into the stream.
    for (int i = 0; i < 4; i++) begin w[i] = 16'($urandom); a_data[i*16 +: 16] = w[i]; end
    a_valid = 4'hF;
    @(negedge clk);
    a_valid = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin a_valid = 4'hF; a_data = ~a_data; end
      if (k == 1) a_valid = '0;
      got = {a_ovalid, a_olast, a_busy, a_odata};
      exp = exp_word(k, 4, (k < 4) ? w[k] : 16'h0);
      n_chk++;
      if (got !== exp || a_eov !== (k >= 1)) begin
        n_fail++; $display("FAIL overrun_mid k=%0d got=%h eov=%b exp=%h eov=%b", k, got, a_eov, exp, (k >= 1));
      end
    end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    // Second result arrives on the last-element cycle.
    for (int i = 0; i < 4; i++) begin w[i] = 16'($urandom); a_data[i*16 +: 16] = w[i]; end
    a_valid = 4'hF;
    @(negedge clk);
    a_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) begin a_valid = 4'hF; a_data = ~a_data; end
      if (k == 3) a_valid = '0;
      got = {a_ovalid, a_olast, a_busy, a_odata};
      exp = exp_word(k, 4, (k < 4) ? w[k] : 16'h0);
      n_chk++;
      if (got !== exp || a_eov !== (k >= 3)) begin
        n_fail++; $display("FAIL overrun_last k=%0d got=%h eov=%b exp=%h eov=%b", k, got, a_eov, exp, (k >= 3));
      end
    end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] w [4];
    logic [20:0] gotr;
    logic [18:0] got, exp;
    // Leave a sticky flag set so reset has something to clear.
    a_valid = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < 4; i++) a_data[i*16 +: 16] = 16'($urandom);
    a_valid = 4'hF;
    @(negedge clk);
    a_valid = '0;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (a_ovalid !== 1'b1 || a_emm !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre valid=%b emm=%b exp=1/1", a_ovalid, a_emm);
    end
    #2 rst = 1'b1;
    #1;
    gotr = {a_ovalid, a_olast, a_busy, a_odata, a_eov, a_emm};
    n_chk++;
    if (gotr !== '0) begin n_fail++; $display("FAIL arst_immediate got=%h exp=0", gotr); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (a_ovalid !== 1'b0) begin n_fail++; $display("FAIL arst_abandon k=%0d valid=%b exp=0", k, a_ovalid); end
    end
    w[0] = 16'hDDDD; w[1] = 16'hCCCC; w[2] = 16'hBBBB; w[3] = 16'hAAAA;
    for (int i = 0; i < 4; i++) a_data[i*16 +: 16] = w[i];
    a_valid = 4'hF;
    @(negedge clk);
    a_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = {a_ovalid, a_olast, a_busy, a_odata};
      exp = exp_word(k, 4, (k < 4) ? w[k] : 16'h0);
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL arst_restream k=%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [8];
    logic [18:0] got, exp;
    for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) a_data[i*16 +: 16] = w[i];
    a_valid = 4'hF;
    @(negedge clk);
    a_valid = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 3) begin
        for (int i = 0; i < 4; i++) a_data[i*16 +: 16] = w[4 + i];
        a_valid = 4'hF;
      end
      if (k == 4) a_valid = '0;
      // First stream at k=0..3, idle gap at k=4, second stream at k=5..8.
      if (k < 5) exp = exp_word(k, 4, (k < 4) ? w[k] : 16'h0);
      else       exp = exp_word(k - 5, 4, (k < 9) ? w[k - 1] : 16'h0);
      got = {a_ovalid, a_olast, a_busy, a_odata};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL b2b k=%0d got=%h exp=%h", k, got, exp); end
    end
    n_chk++;
    if ({a_eov, a_emm} !== 2'b00) begin n_fail++; $display("FAIL b2b_no_err got=%b exp=00", {a_eov, a_emm}); end
  endtask

  task automatic test_wide();
    logic [15:0] w [30];
    logic [18:0] got, exp;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 30; i++) w[i] = 16'($urandom);
      w[3] = 16'h8000; w[17] = 16'h7FFF; w[29 - p] = 16'h8000;
      for (int i = 0; i < 30; i++) b_data[i*16 +: 16] = w[i];
      b_valid = '1;
      @(negedge clk);
      b_valid = '0;
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        got = {b_ovalid, b_olast, b_busy, b_odata};
        exp = exp_word(k, 30, (k < 30) ? w[k] : 16'h0);
        n_chk++;
        if (got !== exp) begin n_fail++; $display("FAIL wide p=%0d k=%0d got=%h exp=%h", p, k, got, exp); end
      end
    end
    n_chk++;
    if ({b_eov, b_emm} !== 2'b00) begin n_fail++; $display("FAIL wide_no_err got=%b exp=00", {b_eov, b_emm}); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mismatch();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
